syn_gpu_job_dispatcher: RTL and testbench

SYN_GPU_JOB_DISPATCHER -- requirements
Module: syn_gpu_job_dispatcher

---
 rtl/syn_gpu_pkg.sv | 36 +++
 rtl/syn_gpu_core_job_intf.sv | 29 ++
 rtl/syn_gpu_job_wdog.sv | 27 ++
 rtl/syn_gpu_job_dispatcher.sv | 122 ++++++++++++
 tb/tb_syn_gpu_job_dispatcher.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/syn_gpu_pkg.sv
// Shared job descriptors, job-type codes and dispatcher state encoding
// for the GPU job dispatcher slice.
package syn_gpu_pkg;

   typedef struct packed {
      logic [11:0] x0;
      logic [11:0] y0;
      logic [11:0] x1;
      logic [11:0] y1;
      logic [23:0] color;
   } gpu_draw_job_t;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic [11:0] w;
      logic [11:0] h;
      logic [23:0] color;
   } gpu_fill_job_t;

   typedef enum logic [1:0] {
      JOB_DRAW  = 2'd0,
      JOB_FILL  = 2'd1,
      JOB_RSVD2 = 2'd2,
      JOB_RSVD3 = 2'd3
   } job_type_e;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE_EUC,
      WAIT_EUC,
      ISSUE_PIC,
      WAIT_PIC
   } gpu_state_e;

endpackage

// File: rtl/syn_gpu_core_job_intf.sv
// Job hand-off between the dispatcher (master) and the euclid/picasso
// engines: start strobe and descriptor out, busy/done back.
interface syn_gpu_core_job_intf;

   logic                       euclid_job_start;
   syn_gpu_pkg::gpu_draw_job_t euclid_job_data;
   logic                       euclid_busy;
   logic                       euclid_job_done;

   logic                       picasso_job_start;
   syn_gpu_pkg::gpu_fill_job_t picasso_job_data;
   logic                       picasso_busy;
   logic                       picasso_job_done;

   modport master (
      output euclid_job_start, euclid_job_data,
      input  euclid_busy, euclid_job_done,
      output picasso_job_start, picasso_job_data,
      input  picasso_busy, picasso_job_done
   );

   modport slave (
      input  euclid_job_start, euclid_job_data,
      output euclid_busy, euclid_job_done,
      input  picasso_job_start, picasso_job_data,
      output picasso_busy, picasso_job_done
   );

endinterface

// File: rtl/syn_gpu_job_wdog.sv
// Engine watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle the count would reach the limit.
module syn_gpu_job_wdog #(
   parameter int unsigned W = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic         expire
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + W'(1);
      end
   end

   // Expiry is flagged during the limit-th enabled cycle itself.
   assign expire = enable && ((count + W'(1)) == limit);

endmodule

// File: rtl/syn_gpu_job_dispatcher.sv
// Accepts host draw/fill jobs and issues them to the euclid/picasso engines.
// Optional watchdog timeout enabled by defining SYN_GPU_JOB_TIMEOUT_EN.
module syn_gpu_job_dispatcher
   import syn_gpu_pkg::*;
#(
   parameter int unsigned JOB_TIMEOUT_CYC = 4095
) (
   input  logic                        clk_ir,
   input  logic                        rst_il,
   input  logic                        job_valid_i,
   input  logic [1:0]                  job_type_i,
   input  gpu_draw_job_t               job_draw_i,
   input  gpu_fill_job_t               job_fill_i,
   output logic                        job_ready_o,
   syn_gpu_core_job_intf.master        job_intf,
   output logic                        core_busy_o,
   output logic                        core_done_o,
   output logic [1:0]                  core_err_o
);

   gpu_state_e    state, state_nxt;
   gpu_draw_job_t euc_data;
   gpu_fill_job_t pic_data;
   logic          euc_start, pic_start;
   logic          load_euc, load_pic;
   logic          done_nxt;
   logic [1:0]    err_nxt;
   logic          timeout;

   always_comb begin
      state_nxt   = state;
      job_ready_o = 1'b0;
      euc_start   = 1'b0;
      pic_start   = 1'b0;
      load_euc    = 1'b0;
      load_pic    = 1'b0;
      done_nxt    = 1'b0;
      err_nxt     = '0;
      case (state)
         IDLE: begin
            job_ready_o = 1'b1;
            if (job_valid_i) begin
               case (job_type_i)
                  JOB_DRAW: begin load_euc = 1'b1; state_nxt = ISSUE_EUC; end
                  JOB_FILL: begin load_pic = 1'b1; state_nxt = ISSUE_PIC; end
                  default:  err_nxt[0] = 1'b1;
               endcase
            end
         end
         ISSUE_EUC: if (!job_intf.euclid_busy) begin
            euc_start = 1'b1;
            state_nxt = WAIT_EUC;
         end
         ISSUE_PIC: if (!job_intf.picasso_busy) begin
            pic_start = 1'b1;
            state_nxt = WAIT_PIC;
         end
         // Done outranks a coincident watchdog expiry.
         WAIT_EUC: if (job_intf.euclid_job_done) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end else if (timeout) begin
            err_nxt[1] = 1'b1;
            state_nxt  = IDLE;
         end
         WAIT_PIC: if (job_intf.picasso_job_done) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end else if (timeout) begin
            err_nxt[1] = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_ir) begin
      if (rst_il) begin
         state       <= IDLE;
         euc_data    <= '0;
         pic_data    <= '0;
         core_done_o <= 1'b0;
         core_err_o  <= '0;
      end else begin
         state       <= state_nxt;
         core_done_o <= done_nxt;
         core_err_o  <= err_nxt;
         if (load_euc) euc_data <= job_draw_i;
         if (load_pic) pic_data <= job_fill_i;
      end
   end

`ifdef SYN_GPU_JOB_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(JOB_TIMEOUT_CYC + 1);

   logic in_wait;
   logic enter_wait;

   assign in_wait    = (state == WAIT_EUC) || (state == WAIT_PIC);
   assign enter_wait = euc_start || pic_start;

   syn_gpu_job_wdog #(
      .W (WD_W)
   ) u_wdog (
      .clk    (clk_ir),
      .rst    (rst_il),
      .clear  (enter_wait),
      .enable (in_wait),
      .limit  (WD_W'(JOB_TIMEOUT_CYC)),
      .expire (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   assign core_busy_o                = (state != IDLE);
   assign job_intf.euclid_job_start  = euc_start;
   assign job_intf.euclid_job_data   = euc_data;
   assign job_intf.picasso_job_start = pic_start;
   assign job_intf.picasso_job_data  = pic_data;

endmodule

// File: tb/tb_syn_gpu_job_dispatcher.sv
// Directed + random bench for syn_gpu_job_dispatcher with a job-level
// reference model; timeout expectations follow SYN_GPU_JOB_TIMEOUT_EN.
module tb_syn_gpu_job_dispatcher;
   import syn_gpu_pkg::*;

   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          job_valid;
   logic [1:0]    job_type;
   gpu_draw_job_t draw;
   gpu_fill_job_t fill;
   logic          job_ready;
   logic          core_busy;
   logic          core_done;
   logic [1:0]    core_err;

   syn_gpu_core_job_intf job_if ();

   syn_gpu_job_dispatcher #(
      .JOB_TIMEOUT_CYC (TO)
   ) dut (
      .clk_ir      (clk),
      .rst_il      (rst),
      .job_valid_i (job_valid),
      .job_type_i  (job_type),
      .job_draw_i  (draw),
      .job_fill_i  (fill),
      .job_ready_o (job_ready),
      .job_intf    (job_if),
      .core_busy_o (core_busy),
      .core_done_o (core_done),
      .core_err_o  (core_err)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: one outstanding job, whether it has been started,
   // how long it has waited, and the pulses due this cycle.
   bit            m_active, m_pic, m_started, m_done;
   logic [1:0]    m_err;
   int            m_wait;
   gpu_draw_job_t m_draw;
   gpu_fill_job_t m_fill;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [1:0] t, input bit eb, input bit ed,
                        input bit pb, input bit pd);
      logic [95:0] r;
      job_valid = v;
      job_type  = t;
      r = {$urandom(), $urandom(), $urandom()};
      draw = r[71:0];
      r = {$urandom(), $urandom(), $urandom()};
      fill = r[71:0];
      job_if.euclid_busy      = eb;
      job_if.euclid_job_done  = ed;
      job_if.picasso_busy     = pb;
      job_if.picasso_job_done = pd;
   endtask

   task automatic step();
      bit eng_busy, eng_done;
      #1;
      eng_busy = m_pic ? job_if.picasso_busy : job_if.euclid_busy;
      eng_done = m_pic ? job_if.picasso_job_done : job_if.euclid_job_done;
      chk("job_ready", 72'(job_ready), 72'(!m_active));
      chk("core_busy", 72'(core_busy), 72'(m_active));
      chk("core_done", 72'(core_done), 72'(m_done));
      chk("core_err", 72'(core_err), 72'(m_err));
      chk("euc_start", 72'(job_if.euclid_job_start),
          72'(m_active && !m_pic && !m_started && !eng_busy));
      chk("pic_start", 72'(job_if.picasso_job_start),
          72'(m_active && m_pic && !m_started && !eng_busy));
      chk("euc_data", 72'(job_if.euclid_job_data), 72'(m_draw));
      chk("pic_data", 72'(job_if.picasso_job_data), 72'(m_fill));

      if (rst) begin
         m_active = 0; m_started = 0; m_done = 0; m_err = '0; m_wait = 0;
         m_draw = '0; m_fill = '0;
      end else begin
         m_done = 0;
         m_err  = '0;
         if (!m_active) begin
            if (job_valid) begin
               if (job_type == 2'd0) begin
                  m_active = 1; m_pic = 0; m_started = 0; m_draw = draw;
               end else if (job_type == 2'd1) begin
                  m_active = 1; m_pic = 1; m_started = 0; m_fill = fill;
               end else begin
                  m_err = 2'b01;
               end
            end
         end else if (!m_started) begin
            if (!eng_busy) begin
               m_started = 1;
               m_wait    = 0;
            end
         end else if (eng_done) begin
            m_active = 0;
            m_done   = 1;
         end else begin
`ifdef SYN_GPU_JOB_TIMEOUT_EN
            m_wait++;
            if (m_wait == TO) begin
               m_active = 0;
               m_err    = 2'b10;
            end
`endif
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      m_active = 0; m_pic = 0; m_started = 0; m_done = 0; m_err = '0; m_wait = 0;
      m_draw = '0; m_fill = '0;
      rst = 1'b1;
      drive(0, 2'd0, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);

      // Reset state
      step();
      step();
      rst = 1'b0;

      // Spurious euclid done while idle
      drive(0, 2'd0, 0, 1, 0, 0); step();
      drive(0, 2'd0, 0, 0, 0, 0); step();

      // Draw job: start next cycle, done seen on the start cycle is ignored
      drive(1, 2'd0, 0, 0, 0, 0); step();
      drive(1, 2'd1, 0, 1, 0, 0); step();
      for (int i = 0; i < 9; i++) begin drive(1, 2'(i), 0, 0, 0, 0); step(); end
      drive(0, 2'd0, 0, 1, 0, 0); step();
      drive(0, 2'd0, 0, 0, 0, 0); step();
      step();

      // Fill job with picasso busy for 5 cycles
      drive(1, 2'd1, 0, 0, 1, 0); step();
      for (int i = 0; i < 5; i++) begin drive(0, 2'd0, 0, 0, 1, 0); step(); end
      drive(0, 2'd0, 0, 0, 0, 0); step();
      for (int i = 0; i < 3; i++) begin drive(0, 2'd0, 0, 1, 0, 0); step(); end
      drive(0, 2'd0, 0, 0, 0, 1); step();
      drive(0, 2'd0, 0, 0, 0, 0); step();

      // Illegal type
      drive(1, 2'd3, 0, 0, 0, 0); step();
      drive(0, 2'd0, 0, 0, 0, 0); step();
      step();
      drive(1, 2'd2, 0, 0, 0, 0); step();
      drive(0, 2'd0, 0, 0, 0, 0); step();

      // No done: times out after TO wait cycles, or stays busy without the watchdog
      drive(1, 2'd0, 0, 0, 0, 0); step();
      drive(0, 2'd0, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++) step();
      drive(0, 2'd0, 0, 1, 0, 0); step();
      drive(0, 2'd0, 0, 0, 0, 0); step();

      // Done on the same cycle the watchdog would expire
      drive(1, 2'd1, 0, 0, 0, 0); step();
      drive(0, 2'd0, 0, 0, 0, 0); step();
      for (int i = 0; i < TO - 1; i++) step();
      drive(0, 2'd0, 0, 0, 0, 1); step();
      drive(0, 2'd0, 0, 0, 0, 0); step();
      step();

      // Reset while waiting on picasso, late done ignored, new job accepted at once
      drive(1, 2'd1, 0, 0, 0, 0); step();
      drive(0, 2'd0, 0, 0, 0, 0); step();
      for (int i = 0; i < 3; i++) step();
      rst = 1'b1; step();
      rst = 1'b0;
      drive(0, 2'd0, 0, 0, 0, 1); step();
      drive(1, 2'd0, 0, 0, 0, 0); step();
      drive(0, 2'd0, 0, 0, 0, 0); step();
      drive(0, 2'd0, 0, 1, 0, 0); step();
      drive(0, 2'd0, 0, 0, 0, 0); step();

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(99) < 2);
         drive($urandom_range(1), 2'($urandom_range(3)),
               $urandom_range(9) < 3, $urandom_range(19) < 3,
               $urandom_range(9) < 3, $urandom_range(19) < 3);
         step();
      end
      rst = 1'b0;
      drive(0, 2'd0, 0, 0, 0, 0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
